bfp_block_sequencer: RTL and testbench
======================================

# bfp_block_sequencer

Controller that feeds the BFP mantissa-adjust datapath one vector at a time. It accepts a V-element vector as V/P partitions of P packed elements, buffers the whole vector, and finds the largest exponent across all partitions. It then issues the partitions back-to-back, each tagged with that block exponent, so every partition is shifted against the same vector-wide exponent. It sits between the FP-to-BFP field splitter and the mantissa-adjust stage.

## Interface
- V, 16, vector length in elements; must be a multiple of P.
- P, 16, elements per partition (datapath width).
- BIT, 32, source float width.
- FPM, 23, source float mantissa width.
- BFPM, 4, truncated BFP mantissa width.
- Derived (local): EXP = BIT-FPM-1; NPART = V/P; element width EW = BFPM+EXP+1, packed as {sign, exp[EXP-1:0], mant[BFPM-1:0]}.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  partition beat present.
- in_ready  out  1  block accepts a beat.
- in_vect  in  P×EW  input partition.
- out_valid  out  1  drives invals_rdy of the datapath.
- out_vect  out  P×EW  partition to adjust.
- out_exp  out  EXP  block exponent (vector-wide max).
- out_part  out  $clog2(NPART)+1  index of the issued partition.
- out_last  out  1  final partition of the vector.
- vec_done  out  1  one-cycle pulse after the final partition is issued.

## Operation
- FSM has two states, LOAD and ISSUE. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each beat (in_valid&in_ready) is written to buffer slot ld_cnt.
  - max_exp_q is updated to max(max_exp_q, P-wide max of the beat's exp fields). On beat 0 it is the beat max alone, not merged.
  - ld_cnt increments per beat.
  - On beat NPART-1: ld_cnt←0, then go to ISSUE.
- ISSUE:
  - in_ready=0. in_valid is ignored and does not stall.
  - out_valid=1 every cycle.
  - out_vect=buffer[is_cnt], out_part=is_cnt, out_exp=max_exp_q (constant for the whole vector).
  - out_last=(is_cnt==NPART-1).
  - After the last partition: is_cnt←0, go to LOAD, and pulse vec_done in the following cycle.
- No downstream backpressure; the datapath accepts every cycle.
- Exponents compare unsigned. Ties make no difference. An all-zero exponent vector gives out_exp=0.
- Element fields are passed through unmodified. The sign bit is not used for the max.
- NPART==1: a single LOAD beat, then a single ISSUE cycle with out_last=1.
- Reset values (asserted at any time, including mid-LOAD or mid-ISSUE):
  - state=LOAD, ld_cnt=is_cnt=0, max_exp_q=0.
  - out_valid=out_last=vec_done=0, out_exp=0, out_part=0, out_vect=0.
  - Buffer contents are don't-care.

## Timing
- All outputs are registered. The output registers load on the same edge that enters or advances ISSUE.
- The last input beat accepted at edge t gives out_valid=1 (partition 0) after edge t.
- Partition k is valid after edge t+k. out_last is high after edge t+NPART-1.
- in_ready returns high and vec_done pulses after edge t+NPART.
- Steady-state throughput: one vector per 2·NPART cycles when in_valid is held high.
- A beat offered while in_ready=0 must be held by the source (standard valid/ready).

## Configuration
- BFP_SEQ_FLUSH_EN defined:
  - Adds input port flush (1 bit, synchronous, active-high).
  - flush=1 at an edge forces LOAD, ld_cnt=is_cnt=0, max_exp_q=0, and out_valid=out_last=0 after that edge.
  - No vec_done pulse for the aborted vector.
  - flush overrides a simultaneous accepted beat, which is dropped.
- Undefined: the flush port does not exist. A vector, once started, always completes.

## Structure
- bfp_pkg holds:
  - the exp_width(BIT,FPM) function;
  - the element field offsets (sign, exp, mant positions);
  - typedef enum logic {LOAD, ISSUE} bfp_seq_state_t.
- Sub-module bfp_max_exp: P-input unsigned max tree over the exp fields of one partition, parameterised by P and EXP. It is purely combinational and is instantiated once.

## Test plan
All scenarios use V=16, P=4, BIT=32, FPM=23, BFPM=4 (EXP=8, NPART=4).
- Exponents per beat 10/20/15/5 -> out_exp=20 on all 4 ISSUE cycles; out_part 0,1,2,3; out_last only on part 3; vec_done one cycle later.
- Back-to-back vectors with max 200 then 3 -> second vector's out_exp=3 (no carry-over of the first max); in_ready low exactly 4 cycles per vector.
- in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats buffered in order; out_vect equals the accepted beats bit-for-bit.
- reset_n asserted after 2 beats -> all outputs 0 immediately; a fresh 4-beat vector with max 7 gives out_exp=7.
- All exponents 0 plus all sign bits 1 -> out_exp=0; signs preserved in out_vect.
- With BFP_SEQ_FLUSH_EN: flush during ISSUE part 1 -> out_valid=0 the next cycle, no vec_done, in_ready=1; next vector issues normally.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared types and element layout helpers for the BFP block sequencer.
// Element packing is {sign, exp[EXP-1:0], mant[BFPM-1:0]}.
package bfp_pkg;

    typedef enum logic {LOAD, ISSUE} bfp_seq_state_t;

    function automatic int exp_width(input int bit_w, input int fpm_w);
        return bit_w - fpm_w - 1;
    endfunction

    function automatic int mant_lsb();
        return 0;
    endfunction

    function automatic int exp_lsb(input int bfpm_w);
        return bfpm_w;
    endfunction

    function automatic int sign_pos(input int bfpm_w, input int exp_w);
        return bfpm_w + exp_w;
    endfunction

endpackage

// File: rtl/bfp_max_exp.sv
// Combinational unsigned max over the P exponent fields of one partition.
// Inputs are zero-padded to a power of two and reduced as a binary tree.
module bfp_max_exp #(
    parameter int P   = 16,
    parameter int EXP = 8
) (
    input  logic [P-1:0][EXP-1:0] exp_i,
    output logic [EXP-1:0]        max_o
);

    localparam int NP = 1 << $clog2(P);

    logic [EXP-1:0] node [2*NP-1];

    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < P) begin : g_real
            assign node[NP-1+i] = exp_i[i];
        end else begin : g_pad
            assign node[NP-1+i] = '0;
        end
    end

    for (genvar i = 0; i < NP - 1; i++) begin : g_node
        assign node[i] = (node[2*i+1] > node[2*i+2]) ? node[2*i+1] : node[2*i+2];
    end

    assign max_o = node[0];

endmodule

// File: rtl/bfp_block_sequencer.sv
// Buffers one V-element vector (NPART partitions), then issues it back-to-back
// tagged with the vector-wide max exponent. Optional flush port: BFP_SEQ_FLUSH_EN.
module bfp_block_sequencer
    import bfp_pkg::*;
#(
    parameter  int V     = 16,
    parameter  int P     = 16,
    parameter  int BIT   = 32,
    parameter  int FPM   = 23,
    parameter  int BFPM  = 4,
    localparam int EXP   = exp_width(BIT, FPM),
    localparam int NPART = V / P,
    localparam int EW    = sign_pos(BFPM, EXP) + 1,
    localparam int PW    = $clog2(NPART) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef BFP_SEQ_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [P-1:0][EW-1:0]  in_vect,
    output logic                  out_valid,
    output logic [P-1:0][EW-1:0]  out_vect,
    output logic [EXP-1:0]        out_exp,
    output logic [PW-1:0]         out_part,
    output logic                  out_last,
    output logic                  vec_done
);

    localparam int            IW   = (NPART > 1) ? $clog2(NPART) : 1;
    localparam logic [PW-1:0] LAST = PW'(NPART - 1);

    typedef logic [P-1:0][EW-1:0] part_t;

    bfp_seq_state_t        state_q, state_d;
    logic [PW-1:0]         ld_cnt_q, ld_cnt_d, is_cnt_q, is_cnt_d, nxt;
    logic [EXP-1:0]        max_exp_q, max_exp_d, beat_max;
    logic [P-1:0][EXP-1:0] beat_exp;
    part_t                 buf_q [NPART];
    part_t                 slot0;
    logic                  beat, flush_w;

    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  vec_done_q, vec_done_d;
    part_t                 out_vect_q, out_vect_d;
    logic [EXP-1:0]        out_exp_q, out_exp_d;
    logic [PW-1:0]         out_part_q, out_part_d;

`ifdef BFP_SEQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    for (genvar l = 0; l < P; l++) begin : g_lane
        assign beat_exp[l] = in_vect[l][exp_lsb(BFPM) +: EXP];
    end

    bfp_max_exp #(.P(P), .EXP(EXP)) u_max (
        .exp_i (beat_exp),
        .max_o (beat_max)
    );

    assign in_ready = (state_q == LOAD);
    assign beat     = in_valid && in_ready && !flush_w;
    // With a single partition, slot 0 is written on the same edge that starts ISSUE.
    assign slot0    = (ld_cnt_q == '0) ? in_vect : buf_q[0];
    assign nxt      = is_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        is_cnt_d    = is_cnt_q;
        max_exp_d   = max_exp_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        vec_done_d  = 1'b0;
        out_vect_d  = '0;
        out_exp_d   = '0;
        out_part_d  = '0;
        case (state_q)
            LOAD: begin
                if (beat) begin
                    max_exp_d = (ld_cnt_q == '0 || beat_max > max_exp_q) ? beat_max : max_exp_q;
                    if (ld_cnt_q == LAST) begin
                        ld_cnt_d    = '0;
                        state_d     = ISSUE;
                        out_valid_d = 1'b1;
                        out_vect_d  = slot0;
                        out_exp_d   = max_exp_d;
                        out_last_d  = (NPART == 1);
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (is_cnt_q == LAST) begin
                    is_cnt_d   = '0;
                    state_d    = LOAD;
                    vec_done_d = 1'b1;
                end else begin
                    is_cnt_d    = nxt;
                    out_valid_d = 1'b1;
                    out_vect_d  = buf_q[nxt[IW-1:0]];
                    out_exp_d   = max_exp_q;
                    out_part_d  = nxt;
                    out_last_d  = (nxt == LAST);
                end
            end
            default: state_d = LOAD;
        endcase
        if (flush_w) begin
            state_d     = LOAD;
            ld_cnt_d    = '0;
            is_cnt_d    = '0;
            max_exp_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            vec_done_d  = 1'b0;
            out_vect_d  = '0;
            out_exp_d   = '0;
            out_part_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) buf_q[ld_cnt_q[IW-1:0]] <= in_vect;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            is_cnt_q    <= '0;
            max_exp_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            vec_done_q  <= 1'b0;
            out_vect_q  <= '0;
            out_exp_q   <= '0;
            out_part_q  <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            is_cnt_q    <= is_cnt_d;
            max_exp_q   <= max_exp_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            vec_done_q  <= vec_done_d;
            out_vect_q  <= out_vect_d;
            out_exp_q   <= out_exp_d;
            out_part_q  <= out_part_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_vect  = out_vect_q;
    assign out_exp   = out_exp_q;
    assign out_part  = out_part_q;
    assign out_last  = out_last_q;
    assign vec_done  = vec_done_q;

endmodule

// File: tb/tb_bfp_block_sequencer.sv
// Directed bench for bfp_block_sequencer with V=16, P=4 (NPART=4, EXP=8, EW=13).
module tb_bfp_block_sequencer;

    localparam int V = 16, P = 4, BIT = 32, FPM = 23, BFPM = 4;
    localparam int EXP = 8, EW = 13, NPART = 4, PW = 3;

    typedef logic [P-1:0][EW-1:0] beat_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    beat_t          in_vect = '0;
    logic           out_valid;
    beat_t          out_vect;
    logic [EXP-1:0] out_exp;
    logic [PW-1:0]  out_part;
    logic           out_last;
    logic           vec_done;
`ifdef BFP_SEQ_FLUSH_EN
    logic           flush = 1'b0;
`endif

    int    checks = 0;
    int    errors = 0;
    int    cyc;
    beat_t cur [NPART];
    logic  hold_valid = 1'b0;

    always #5 clk = ~clk;

    bfp_block_sequencer #(.V(V), .P(P), .BIT(BIT), .FPM(FPM), .BFPM(BFPM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef BFP_SEQ_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vect   (in_vect),
        .out_valid (out_valid),
        .out_vect  (out_vect),
        .out_exp   (out_exp),
        .out_part  (out_part),
        .out_last  (out_last),
        .vec_done  (vec_done)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic beat_t mk(input int e0, input int e1, input int e2, input int e3,
                                 input int m, input logic [3:0] sg);
        beat_t b;
        b[0] = {sg[0], 8'(e0), 4'(m)};
        b[1] = {sg[1], 8'(e1), 4'(m + 1)};
        b[2] = {sg[2], 8'(e2), 4'(m + 2)};
        b[3] = {sg[3], 8'(e3), 4'(m + 3)};
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers cur[] in order; vpat[c] gates in_valid on cycle c, then valid stays high.
    task automatic load_vec(input logic [7:0] vpat, input int npat, output int ncyc);
        int idx = 0;
        int c   = 0;
        logic acc;
        while (idx < NPART && c < 40) begin
            in_valid = (c < npat) ? vpat[c] : 1'b1;
            in_vect  = cur[idx];
            acc      = in_valid && in_ready;
            tick();
            if (acc) idx++;
            c++;
        end
        in_valid = hold_valid;
        ncyc     = c;
        chk("load_beats", idx, NPART);
    endtask

    task automatic check_issue(input int ex);
        for (int k = 0; k < NPART; k++) begin
            chk("out_valid", out_valid, 1);
            chk("out_part", out_part, k);
            chk("out_vect", out_vect, cur[k]);
            chk("out_exp", out_exp, ex);
            chk("out_last", out_last, (k == NPART - 1));
            chk("in_ready_issue", in_ready, 0);
            chk("vec_done_early", vec_done, 0);
            tick();
        end
        chk("vec_done", vec_done, 1);
        chk("out_valid_end", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_done"}, vec_done, 0);
        chk({tag, "_exp"}, out_exp, 0);
        chk({tag, "_part"}, out_part, 0);
        chk({tag, "_vect"}, out_vect, 0);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst");
        reset_n = 1'b1;
        tick();

        // Per-beat maxima 10/20/15/5
        cur[0] = mk(3, 10, 7, 1, 1, 4'b0101);
        cur[1] = mk(20, 2, 19, 0, 5, 4'b1010);
        cur[2] = mk(15, 15, 4, 9, 9, 4'b0011);
        cur[3] = mk(5, 0, 5, 2, 12, 4'b1100);
        load_vec(8'hFF, 0, cyc);
        chk("load_cycles", cyc, 4);
        check_issue(20);
        tick();
        chk("vec_done_pulse", vec_done, 0);

        // Back-to-back vectors with in_valid held high, max 200 then 3
        hold_valid = 1'b1;
        cur[0] = mk(200, 17, 3, 0, 2, 4'b1111);
        cur[1] = mk(1, 2, 3, 4, 6, 4'b0000);
        cur[2] = mk(199, 0, 0, 0, 3, 4'b1001);
        cur[3] = mk(50, 60, 70, 80, 7, 4'b0110);
        load_vec(8'hFF, 0, cyc);
        check_issue(200);
        cur[0] = mk(3, 1, 0, 2, 0, 4'b0001);
        cur[1] = mk(0, 0, 3, 3, 4, 4'b0010);
        cur[2] = mk(2, 2, 2, 2, 8, 4'b0100);
        cur[3] = mk(1, 0, 0, 3, 11, 4'b1000);
        load_vec(8'hFF, 0, cyc);
        chk("b2b_load_cycles", cyc, 4);
        check_issue(3);
        hold_valid = 1'b0;
        in_valid   = 1'b0;

        // in_valid pattern 1,0,0,1,1,0,1
        cur[0] = mk(33, 34, 35, 36, 1, 4'b1110);
        cur[1] = mk(90, 12, 44, 8, 3, 4'b0111);
        cur[2] = mk(91, 0, 1, 2, 5, 4'b1011);
        cur[3] = mk(17, 89, 100, 99, 13, 4'b1101);
        load_vec(8'b0101_1001, 7, cyc);
        chk("toggle_cycles", cyc, 7);
        check_issue(100);
        tick();

        // Reset after two beats, then a fresh vector
        in_valid = 1'b1;
        in_vect  = mk(250, 250, 250, 250, 0, 4'b1111);
        tick();
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_idle("rst_load");
        #1;
        reset_n = 1'b1;
        tick();
        cur[0] = mk(1, 7, 2, 0, 2, 4'b0101);
        cur[1] = mk(6, 6, 6, 6, 4, 4'b1010);
        cur[2] = mk(0, 0, 0, 0, 6, 4'b1111);
        cur[3] = mk(3, 4, 5, 7, 8, 4'b0000);
        load_vec(8'hFF, 0, cyc);
        check_issue(7);
        tick();

        // Reset in the middle of ISSUE
        load_vec(8'hFF, 0, cyc);
        tick();
        reset_n = 1'b0;
        #1;
        check_idle("rst_issue");
        #1;
        reset_n = 1'b1;
        tick();

        // All-zero exponents, all sign bits set
        cur[0] = mk(0, 0, 0, 0, 1, 4'b1111);
        cur[1] = mk(0, 0, 0, 0, 5, 4'b1111);
        cur[2] = mk(0, 0, 0, 0, 9, 4'b1111);
        cur[3] = mk(0, 0, 0, 0, 12, 4'b1111);
        load_vec(8'hFF, 0, cyc);
        check_issue(0);
        tick();

`ifdef BFP_SEQ_FLUSH_EN
        // Flush while partition 1 is on the output
        cur[0] = mk(40, 41, 42, 43, 1, 4'b0011);
        cur[1] = mk(44, 45, 46, 47, 2, 4'b1100);
        cur[2] = mk(48, 9, 9, 9, 3, 4'b0101);
        cur[3] = mk(1, 2, 3, 4, 4, 4'b1010);
        load_vec(8'hFF, 0, cyc);
        tick();
        chk("fl_part1", out_part, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_last", out_last, 0);
        chk("fl_done", vec_done, 0);
        chk("fl_ready", in_ready, 1);
        tick();
        chk("fl_done_late", vec_done, 0);
        cur[0] = mk(5, 6, 7, 8, 0, 4'b1000);
        cur[1] = mk(9, 10, 11, 12, 4, 4'b0100);
        cur[2] = mk(13, 2, 2, 2, 8, 4'b0010);
        cur[3] = mk(0, 1, 0, 1, 12, 4'b0001);
        load_vec(8'hFF, 0, cyc);
        check_issue(13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
